// File: rtl/slice_packer.sv
// rtl/slice_packer.sv - packs RATIO narrow sliced samples into one wide output word
//
// Purpose: sits downstream of bit_slicer. Accepts one IN_WIDTH sample per beat,
// packs RATIO = OUT_WIDTH/IN_WIDTH samples (first sample in the low lane) into
// one OUT_WIDTH word, marks tlast every frame_len words, and zero-pads a
// partial word on flush.
//
// Ports:
//   ACLK, ARESET      clock, synchronous active-high reset
//   enable            gates s_axis_tready; output side keeps draining
//   frame_len         words per frame, 0 = continuous (no tlast)
//   flush             single-cycle pulse, emit partial word zero-padded
//   s_axis_t*         sample input stream (tdata/tvalid/tready)
//   m_axis_t*         packed word output stream (tdata/tvalid/tready/tlast)
//   word_count        total words accepted downstream, wraps at 2^32
//   flush_busy        a flush is pending and not yet completed
module slice_packer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 64,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 enable,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic                 flush,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [31:0]          word_count,
  output logic                 flush_busy
);

  localparam int RATIO  = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W = $clog2(RATIO);
  localparam int PACK_W = OUT_WIDTH - IN_WIDTH;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  // Lanes 0..RATIO-2 are staged here; the last lane goes straight from the
  // input into the output register so a word completes without a bubble.
  logic [PACK_W-1:0]    pack_q;
  logic [LANE_W-1:0]    lane_q;
  logic                 flush_pending_q;
  logic [OUT_WIDTH-1:0] data_q;
  logic                 valid_q;
  logic                 last_q;
  logic [LEN_WIDTH-1:0] frame_cnt_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [31:0]          word_count_q;

  logic                 out_free;
  logic                 at_last;
  logic                 accept;
  logic                 complete;
  logic                 flush_load;
  logic                 load_word;
  logic [OUT_WIDTH-1:0] word_next;
  logic [LEN_WIDTH-1:0] eff_len;
  logic                 word_last;

  // Output register can take a new word if empty or being consumed this cycle.
  assign out_free = !valid_q || m_axis_tready;
  assign at_last  = (lane_q == LAST_LANE);

  // Only the completing lane waits on the output register. Gated by reset so
  // every output reads 0 while reset is held.
  assign s_axis_tready = !ARESET && enable && !flush_pending_q && (!at_last || out_free);

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign complete   = accept && at_last;
  assign flush_load = flush_pending_q && (lane_q != '0) && out_free;
  // complete and flush_load are exclusive: a pending flush blocks input.
  assign load_word  = complete || flush_load;

  // pack_q is cleared on every word load, so unfilled lanes are already zero.
  assign word_next = complete ? {s_axis_tdata, pack_q} : {{IN_WIDTH{1'b0}}, pack_q};

  // frame_len is only looked at on the first word of a frame.
  assign eff_len   = (frame_cnt_q == '0) ? frame_len : len_q;
  assign word_last = (eff_len != '0) && (frame_cnt_q == eff_len - LEN_WIDTH'(1));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pack_q          <= '0;
      lane_q          <= '0;
      flush_pending_q <= 1'b0;
      data_q          <= '0;
      valid_q         <= 1'b0;
      last_q          <= 1'b0;
      frame_cnt_q     <= '0;
      len_q           <= '0;
      word_count_q    <= '0;
    end else begin
      if (accept && !at_last) begin
        pack_q[lane_q*IN_WIDTH +: IN_WIDTH] <= s_axis_tdata;
        lane_q                              <= lane_q + LANE_W'(1);
      end

      if (load_word) begin
        pack_q <= '0;
        lane_q <= '0;
      end

      // An empty flush retires immediately; otherwise it retires on its load.
      // A new pulse always (re)arms it.
      if (flush_pending_q && (lane_q == '0 || flush_load)) begin
        flush_pending_q <= 1'b0;
      end
      if (flush) begin
        flush_pending_q <= 1'b1;
      end

      if (load_word) begin
        data_q  <= word_next;
        valid_q <= 1'b1;
        last_q  <= word_last;
        if (frame_cnt_q == '0) begin
          len_q <= frame_len;
        end
        if (eff_len == '0 || word_last) begin
          frame_cnt_q <= '0;
        end else begin
          frame_cnt_q <= frame_cnt_q + LEN_WIDTH'(1);
        end
      end else if (m_axis_tready) begin
        valid_q <= 1'b0;
      end

      if (valid_q && m_axis_tready) begin
        word_count_q <= word_count_q + 32'd1;
      end
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign word_count    = word_count_q;
  assign flush_busy    = flush_pending_q;

endmodule

// File: tb/tb_slice_packer.sv
// tb/tb_slice_packer.sv - scoreboard bench for slice_packer
module tb_slice_packer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        enable;
  logic [15:0] frame_len;
  logic        flush;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [31:0] word_count;
  logic        flush_busy;

  always #5 ACLK = ~ACLK;

  slice_packer #(.IN_WIDTH(16), .OUT_WIDTH(64), .LEN_WIDTH(16)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .enable        (enable),
    .frame_len     (frame_len),
    .flush         (flush),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .word_count    (word_count),
    .flush_busy    (flush_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int words_seen = 0;
  int stalls = 0;

  // expected words: {tlast, data}
  logic [64:0] exp_q[$];

  // reference packing state
  logic [15:0] acc[4];
  int          m_lane = 0;
  int          m_fcnt = 0;
  int          m_flen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [63:0] d);
    int  eff;
    logic last;
    eff = (m_fcnt == 0) ? int'(frame_len) : m_flen;
    if (m_fcnt == 0) m_flen = int'(frame_len);
    if (eff == 0) begin
      last = 1'b0;
      m_fcnt = 0;
    end else if (m_fcnt == eff - 1) begin
      last = 1'b1;
      m_fcnt = 0;
    end else begin
      last = 1'b0;
      m_fcnt++;
    end
    exp_q.push_back({last, d});
  endtask

  task automatic model_sample(input logic [15:0] d);
    acc[m_lane] = d;
    m_lane++;
    if (m_lane == 4) begin
      push_word({acc[3], acc[2], acc[1], acc[0]});
      m_lane = 0;
      for (int i = 0; i < 4; i++) acc[i] = '0;
    end
  endtask

  task automatic model_flush();
    if (m_lane != 0) begin
      push_word({acc[3], acc[2], acc[1], acc[0]});
      m_lane = 0;
      for (int i = 0; i < 4; i++) acc[i] = '0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_lane = 0;
    m_fcnt = 0;
    m_flen = 0;
    for (int i = 0; i < 4; i++) acc[i] = '0;
  endtask

  // Called at #1 after a posedge; returns at #1 after the accepting edge.
  task automatic send(input logic [15:0] d);
    int t;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    t = 0;
    @(negedge ACLK);
    while (!s_axis_tready && t < 200) begin
      @(negedge ACLK);
      t++;
    end
    if (t >= 200) begin
      check("send_timeout", 64'd1, 64'd0);
      s_axis_tvalid = 1'b0;
      return;
    end
    if (t > 0) stalls++;
    @(posedge ACLK);
    #1;
    s_axis_tvalid = 1'b0;
    model_sample(d);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    model_flush();
    @(posedge ACLK);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge ACLK);
      t++;
    end
    if (t >= 200) check("drain_timeout", 64'd1, 64'd0);
    @(posedge ACLK);
    #1;
  endtask

  // Scoreboard: compare each word as it is handed off downstream.
  always @(negedge ACLK) begin
    if (!ARESET && m_axis_tvalid && m_axis_tready) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", m_axis_tdata, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("word_data", m_axis_tdata, e[63:0]);
        check("word_last", {63'd0, m_axis_tlast}, {63'd0, e[64]});
      end
    end
  end

  initial begin
    int base;
    ARESET        = 1'b1;
    enable        = 1'b0;
    frame_len     = '0;
    flush         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    model_reset();
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;

    // reset state
    check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    check("rst_word_count", {32'd0, word_count}, 64'd0);
    check("rst_flush_busy", {63'd0, flush_busy}, 64'd0);
    check("disabled_tready", {63'd0, s_axis_tready}, 64'd0);

    // basic packing and latency
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) send(16'(i));
    check("lat_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    check("lat_tdata", m_axis_tdata, 64'h0004_0003_0002_0001);
    for (int i = 5; i <= 8; i++) send(16'(i));
    check("lat2_tdata", m_axis_tdata, 64'h0008_0007_0006_0005);
    drain();
    check("t1_word_count", {32'd0, word_count}, 64'd2);

    // framing with continuous stream
    frame_len = 16'd3;
    stalls = 0;
    base = words_seen;
    for (int i = 0; i < 24; i++) send(16'h1000 + 16'(i));
    drain();
    check("t2_stalls", 64'(stalls), 64'd0);
    check("t2_words", 64'(words_seen - base), 64'd6);
    frame_len = 16'd0;

    // backpressure
    base = words_seen;
    m_axis_tready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 12; i++) send(16'h0100 + 16'(i));
      end
      begin
        repeat (10) @(posedge ACLK);
        #1;
        check("bp_tready_low", {63'd0, s_axis_tready}, 64'd0);
        check("bp_held_valid", {63'd0, m_axis_tvalid}, 64'd1);
        check("bp_held_data", m_axis_tdata, 64'h0104_0103_0102_0101);
        m_axis_tready = 1'b1;
      end
    join
    drain();
    check("t3_words", 64'(words_seen - base), 64'd3);

    // partial flush
    base = words_seen;
    send(16'hAAAA);
    send(16'hBBBB);
    pulse_flush();
    check("flush_busy_set", {63'd0, flush_busy}, 64'd1);
    check("flush_no_word_yet", {63'd0, m_axis_tvalid}, 64'd0);
    @(posedge ACLK);
    #1;
    check("flush_busy_clear", {63'd0, flush_busy}, 64'd0);
    check("flush_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    check("flush_tdata", m_axis_tdata, 64'h0000_0000_BBBB_AAAA);
    for (int i = 0; i < 4; i++) send(16'hCC00 + 16'(i));
    drain();
    check("t4_words", 64'(words_seen - base), 64'd2);

    // empty flush
    base = words_seen;
    pulse_flush();
    check("eflush_busy_set", {63'd0, flush_busy}, 64'd1);
    @(posedge ACLK);
    #1;
    check("eflush_busy_clear", {63'd0, flush_busy}, 64'd0);
    check("eflush_no_word", {63'd0, m_axis_tvalid}, 64'd0);
    repeat (3) @(posedge ACLK);
    #1;
    check("t5_words", 64'(words_seen - base), 64'd0);

    // reset mid-operation
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) send(16'hE000 + 16'(i));
    check("pre_rst_held", {63'd0, m_axis_tvalid}, 64'd1);
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    model_reset();
    check("mid_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("mid_rst_tdata", m_axis_tdata, 64'd0);
    check("mid_rst_word_count", {32'd0, word_count}, 64'd0);
    check("mid_rst_tready", {63'd0, s_axis_tready}, 64'd0);
    ARESET = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge ACLK);
    #1;
    for (int i = 1; i <= 4; i++) send(16'h0D00 + 16'(i));
    check("post_rst_tdata", m_axis_tdata, 64'h0D04_0D03_0D02_0D01);
    drain();
    check("post_rst_word_count", {32'd0, word_count}, 64'd1);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
